bsg_one_hot_ptr_sched: RTL and testbench

Round-robin scheduler that shares one modulo one-hot adder (a `bsg_adder_one_hot` with `modulo_p=1`) among `els_p` requesters to advance a single shared one-hot pointer. Each cycle it grants at most one requester, adds that requester's one-hot increment to the pointer, and returns the pre- and post-increment pointers through a one-entry valid/yumi output slot. It sits in front of rotating-buffer and bank-select logic, where several clients reserve slots from one circular one-hot index.

---
 rtl/bsg_one_hot_ptr_sched.sv | 121 ++++++++++++
 tb/tb_bsg_one_hot_ptr_sched.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_one_hot_ptr_sched.sv
// Round-robin scheduler sharing one modulo one-hot adder among els_p requesters
// to advance a shared circular one-hot pointer; results land in a one-entry slot.
//
// Handshakes: a requester i is accepted on the rising edge where v_i[i] and
// yumi_o[i] are both high; the result slot transfers on the edge where v_o and
// yumi_i are both high. yumi_i may only be raised while v_o is high.
module bsg_one_hot_ptr_sched #(
    parameter int width_p = 4,
    parameter int els_p   = 2
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [els_p-1:0]           v_i,
    input  logic [els_p*width_p-1:0]   inc_i,
    output logic [els_p-1:0]           yumi_o,
    output logic                       v_o,
    output logic [els_p-1:0]           id_o,
    output logic [width_p-1:0]         ptr_o,
    output logic [width_p-1:0]         new_ptr_o,
    input  logic                       yumi_i,
    output logic [width_p-1:0]         ptr_r_o
);

    localparam int lg_els_lp = (els_p > 1) ? $clog2(els_p) : 1;

    logic [width_p-1:0]   ptr_r;
    logic [lg_els_lp-1:0] pri_r;
    logic [els_p-1:0]     grant;
    logic [lg_els_lp-1:0] grant_idx;
    logic                 free;
    logic [width_p-1:0]   inc_sel;
    logic [width_p-1:0]   sum;
    logic [width_p-1:0]   rot [width_p];

    assign free    = ~v_o | yumi_i;
    assign ptr_r_o = ptr_r;

    // Scan from lowest to highest priority so the highest-priority valid
    // requester is the last one written.
    always_comb begin
        logic [lg_els_lp:0]   pos;
        logic [lg_els_lp-1:0] idx;
        grant     = '0;
        grant_idx = '0;
        pos       = '0;
        idx       = '0;
        for (int j = els_p - 1; j >= 0; j--) begin
            pos = {1'b0, pri_r} + (lg_els_lp + 1)'(j);
            if (pos >= (lg_els_lp + 1)'(els_p)) begin
                pos = pos - (lg_els_lp + 1)'(els_p);
            end
            idx = pos[lg_els_lp-1:0];
            if (v_i[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    assign yumi_o = (free && !reset_i) ? grant : '0;

    // Increment mux keys off the ungated grant so inc_i never feeds yumi_o.
    always_comb begin
        inc_sel = '0;
        for (int i = 0; i < els_p; i++) begin
            if (grant[i]) begin
                inc_sel = inc_sel | inc_i[i*width_p +: width_p];
            end
        end
    end

    // Modulo one-hot add: rotate the pointer left by the increment's bit index.
    for (genvar k = 0; k < width_p; k++) begin : g_rot
        logic [2*width_p-1:0] dbl;
        assign dbl    = {ptr_r, ptr_r} << k;
        assign rot[k] = inc_sel[k] ? dbl[2*width_p-1:width_p] : '0;
    end

    always_comb begin
        sum = '0;
        for (int k = 0; k < width_p; k++) begin
            sum = sum | rot[k];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_r     <= width_p'(1);
            pri_r     <= '0;
            v_o       <= 1'b0;
            id_o      <= '0;
            ptr_o     <= '0;
            new_ptr_o <= '0;
        end else if (|yumi_o) begin
            ptr_r     <= sum;
            pri_r     <= (grant_idx == lg_els_lp'(els_p - 1)) ? '0
                                                              : grant_idx + lg_els_lp'(1);
            v_o       <= 1'b1;
            id_o      <= yumi_o;
            ptr_o     <= ptr_r;
            new_ptr_o <= sum;
        end else if (yumi_i) begin
            v_o <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            for (int i = 0; i < els_p; i++) begin
                if (v_i[i]) begin
                    assert ($onehot(inc_i[i*width_p +: width_p]))
                    else $error("inc_i of requester %0d is not one-hot", i);
                end
            end
            assert (v_o || !yumi_i)
            else $error("yumi_i asserted while v_o is low");
        end
    end

endmodule

// File: tb/tb_bsg_one_hot_ptr_sched.sv
// Self-checking bench for bsg_one_hot_ptr_sched: directed plan plus random traffic,
// with a cycle model feeding a scoreboard of expected slot contents.
module tb_bsg_one_hot_ptr_sched;
  localparam int W  = 4;
  localparam int E  = 2;
  localparam int SW = E + 2 * W;

  logic           clk;
  logic           reset_i;
  logic [E-1:0]   v_i;
  logic [E*W-1:0] inc_i;
  logic [E-1:0]   yumi_o;
  logic           v_o;
  logic [E-1:0]   id_o;
  logic [W-1:0]   ptr_o;
  logic [W-1:0]   new_ptr_o;
  logic           yumi_i;
  logic [W-1:0]   ptr_r_o;
  logic           deq_en;

  int n_checks = 0;
  int n_errors = 0;

  logic [SW-1:0] exp_q[$];

  logic [W-1:0] m_ptr;
  int           m_pri;
  logic         m_v;
  logic         armed = 1'b0;

  bsg_one_hot_ptr_sched #(.width_p(W), .els_p(E)) dut (
    .clk_i     (clk),
    .reset_i   (reset_i),
    .v_i       (v_i),
    .inc_i     (inc_i),
    .yumi_o    (yumi_o),
    .v_o       (v_o),
    .id_o      (id_o),
    .ptr_o     (ptr_o),
    .new_ptr_o (new_ptr_o),
    .yumi_i    (yumi_i),
    .ptr_r_o   (ptr_r_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // consumer only dequeues while a result is present
  assign yumi_i = deq_en & v_o;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rotl(input logic [W-1:0] p, input logic [W-1:0] inc);
    logic [2*W-1:0] t;
    int k;
    k = 0;
    for (int i = 0; i < W; i++) if (inc[i]) k = i;
    t = {p, p} << k;
    return t[2*W-1:W];
  endfunction

  function automatic logic [E-1:0] model_grant(input logic [E-1:0] v, input int pri);
    for (int j = 0; j < E; j++) begin
      int i;
      i = (pri + j) % E;
      if (v[i]) return E'(1 << i);
    end
    return '0;
  endfunction

  function automatic logic [W-1:0] rand_onehot();
    return W'(1 << $urandom_range(W - 1, 0));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard / cycle model, evaluated mid-cycle once inputs are settled
  always @(negedge clk) begin
    logic [E-1:0]  g;
    logic [W-1:0]  nptr;
    logic [SW-1:0] e;
    int            gi;
    if (reset_i) begin
      check("rst_yumi", 32'(yumi_o), 32'(0));
      m_v   = 1'b0;
      m_ptr = W'(1);
      m_pri = 0;
      exp_q.delete();
      armed = 1'b1;
    end else if (armed) begin
      check("v_o", 32'(v_o), 32'(m_v));
      check("ptr_r", 32'(ptr_r_o), 32'(m_ptr));
      if (v_o && yumi_i) begin
        check("sb_pop", 32'(exp_q.size() != 0), 32'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("slot", 32'({id_o, ptr_o, new_ptr_o}), 32'(e));
        end
      end
      g = (!m_v || yumi_i) ? model_grant(v_i, m_pri) : '0;
      check("grant", 32'(yumi_o), 32'(g));
      if (g != '0) begin
        gi = 0;
        for (int i = 0; i < E; i++) if (g[i]) gi = i;
        nptr = rotl(m_ptr, inc_i[gi*W +: W]);
        exp_q.push_back({g, m_ptr, nptr});
        m_ptr = nptr;
        m_pri = (gi + 1) % E;
        m_v   = 1'b1;
      end else if (yumi_i) begin
        m_v = 1'b0;
      end
    end
  end

  initial begin
    int cur;
    int delta;
    reset_i = 1'b1;
    v_i     = '0;
    inc_i   = {E{W'(1)}};
    deq_en  = 1'b0;
    repeat (3) tick();
    reset_i = 1'b0;

    // reset state
    check("rst_ptr_r", 32'(ptr_r_o), 32'h1);
    check("rst_v_o", 32'(v_o), 32'h0);
    check("rst_id", 32'(id_o), 32'h0);
    check("rst_ptr_o", 32'(ptr_o), 32'h0);
    check("rst_new_ptr", 32'(new_ptr_o), 32'h0);

    // single request
    v_i = 2'b01;
    inc_i[3:0] = 4'b0100;
    deq_en = 1'b1;
    #1;
    check("single_yumi", 32'(yumi_o), 32'h1);
    tick();
    v_i = '0;
    check("single_v", 32'(v_o), 32'h1);
    check("single_id", 32'(id_o), 32'h1);
    check("single_ptr", 32'(ptr_o), 32'h1);
    check("single_new", 32'(new_ptr_o), 32'h4);
    check("single_ptr_r", 32'(ptr_r_o), 32'h4);
    tick();

    // wrap
    v_i = 2'b10;
    inc_i[7:4] = 4'b0100;
    tick();
    check("wrap_ptr", 32'(ptr_o), 32'h4);
    check("wrap_new", 32'(new_ptr_o), 32'h1);
    check("wrap_id", 32'(id_o), 32'h2);
    inc_i[7:4] = 4'b1000;
    tick();
    check("wrap2_new", 32'(new_ptr_o), 32'h8);
    check("wrap2_ptr", 32'(ptr_o), 32'h1);
    v_i = '0;
    tick();

    // round-robin with both requesters active
    v_i = 2'b11;
    for (int i = 0; i < 4; i++) begin
      inc_i = {rand_onehot(), rand_onehot()};
      #1;
      check("rr_grant", 32'(yumi_o), (i % 2 == 0) ? 32'h1 : 32'h2);
      tick();
    end

    // backpressure: slot full, consumer stalls
    deq_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_yumi", 32'(yumi_o), 32'h0);
      check("bp_ptr_r", 32'(ptr_r_o), 32'(m_ptr));
      check("bp_slot", 32'({id_o, ptr_o, new_ptr_o}), 32'(exp_q[0]));
      tick();
    end
    deq_en = 1'b1;
    #1;
    check("bp_release", 32'(yumi_o), 32'h1);
    tick();
    v_i = '0;
    check("bp_result_v", 32'(v_o), 32'h1);
    check("bp_result_id", 32'(id_o), 32'h1);
    tick();

    // exhaustive pointer x increment sweep on requester 0
    cur = 0;
    for (int i = 0; i < W; i++) if (m_ptr[i]) cur = i;
    for (int p = 0; p < W; p++) begin
      for (int k = 0; k < W; k++) begin
        delta = (p - cur + W) % W;
        v_i = 2'b01;
        inc_i[3:0] = W'(1 << delta);
        tick();
        inc_i[3:0] = W'(1 << k);
        tick();
        check("sweep_ptr", 32'(ptr_o), 32'(1 << p));
        check("sweep_new", 32'(new_ptr_o), 32'(1 << ((p + k) % W)));
        cur = (p + k) % W;
      end
    end
    v_i = '0;
    tick();

    // reset while a result is pending and both requesters are active
    deq_en = 1'b0;
    v_i = 2'b11;
    inc_i = {rand_onehot(), rand_onehot()};
    tick();
    tick();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    check("mrst_v", 32'(v_o), 32'h0);
    check("mrst_ptr_r", 32'(ptr_r_o), 32'h1);
    #1;
    check("mrst_first", 32'(yumi_o), 32'h1);
    deq_en = 1'b1;
    tick();
    v_i = '0;
    tick();

    // random traffic
    for (int n = 0; n < 300; n++) begin
      v_i    = E'($urandom_range((1 << E) - 1, 0));
      inc_i  = {rand_onehot(), rand_onehot()};
      deq_en = ($urandom_range(3, 0) != 0);
      tick();
    end
    v_i = '0;
    deq_en = 1'b1;
    repeat (3) tick();
    check("sb_drain", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
